// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, line/address widths and the default access latency.
// Also provides small helpers used by the top level to decode request addresses.
package mem_port_arbiter_pkg;

  localparam int LINE_W      = 128;
  localparam int MEM_AW      = 14;
  localparam int LINE_AW     = MEM_AW - 2;
  localparam int DEF_LATENCY = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Request fields latched at grant time; later input changes are ignored.
  typedef struct packed {
    logic               rd_wr;
    logic [LINE_AW-1:0] line;
    logic [LINE_W-1:0]  din;
  } req_t;

  // Byte-in-line bits [1:0] carry no meaning for 128-bit line accesses.
  function automatic logic [LINE_AW-1:0] addr_to_line(input logic [MEM_AW-1:0] addr);
    return addr[MEM_AW-1:2];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant among two requesters.
// Latency: grant is combinational from the requests; last-grant updates on the accept edge.
// Backpressure: none internally; losers simply keep requesting until accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // 1 = port 2 was granted last; reset value makes port 1 win the first tie.
  logic r_last;

  // Pick the requester that was not served last when both ask at once.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

  // Remember the winner only when the grant is actually taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (i_accept && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two request ports onto one single-port RAM, one transaction at a time.
// Latency: RAM access LATENCY cycles after grant, ack LATENCY+2 cycles after grant.
// Backpressure: a held valid is the only flow control; ack stays up until valid drops.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int RAM_AW  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req1_valid,
  input  logic                req1_rd_wr,
  input  logic [MEM_AW-1:0]   req1_addr,
  input  logic [LINE_W-1:0]   req1_din,
  output logic [LINE_W-1:0]   req1_dout,
  output logic                req1_ack,
  input  logic                req2_valid,
  input  logic                req2_rd_wr,
  input  logic [MEM_AW-1:0]   req2_addr,
  input  logic [LINE_W-1:0]   req2_din,
  output logic [LINE_W-1:0]   req2_dout,
  output logic                req2_ack,
  output logic                ram_en,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [LINE_W-1:0]   ram_wdata,
  input  logic [LINE_W-1:0]   ram_rdata,
  output logic                busy,
  output logic [1:0]          grant
);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_owner;
  logic                r_we;
  logic [RAM_AW-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_dout1;
  logic [LINE_W-1:0]   r_dout2;
  logic                r_ack1;
  logic                r_ack2;

  logic [1:0]          w_req;
  logic [1:0]          w_arb_gnt;
  logic                w_accept;
  logic                w_own_valid;
  req_t                w_sel;
  logic                w_unused_addr_lsbs;

  assign w_req    = {req2_valid, req1_valid};
  assign w_accept = (r_state == ST_IDLE) && (w_req != 2'b00);

  // Valid of whichever port currently owns the RAM; drives RESP exit and abort.
  assign w_own_valid = (r_owner[0] & req1_valid) | (r_owner[1] & req2_valid);

  // Low address bits select a byte within a line and are deliberately dropped.
  assign w_unused_addr_lsbs = ^{req1_addr[1:0], req2_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_arb_gnt)
  );

  // Mux the winning port's request fields so they can be latched in one place.
  always_comb begin
    w_sel = '0;
    if (w_arb_gnt[1]) begin
      w_sel.rd_wr = req2_rd_wr;
      w_sel.line  = addr_to_line(req2_addr);
      w_sel.din   = req2_din;
    end else begin
      w_sel.rd_wr = req1_rd_wr;
      w_sel.line  = addr_to_line(req1_addr);
      w_sel.din   = req1_din;
    end
  end

  // Next-state logic for the grant / wait / access / capture / respond sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_req != 2'b00) w_next_state = ST_WAIT;
      ST_WAIT:    if (r_cnt == '0) w_next_state = ST_ACCESS;
      ST_ACCESS:  w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = w_own_valid ? ST_RESP : ST_IDLE;
      ST_RESP:    if (!w_own_valid) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // State register plus the latched request, latency counter, read data and acks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= 2'b00;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dout1 <= '0;
      r_dout2 <= '0;
      r_ack1  <= 1'b0;
      r_ack2  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_arb_gnt;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_we    <= w_sel.rd_wr;
            r_addr  <= RAM_AW'(w_sel.line);
            r_wdata <= w_sel.din;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          // RAM read data is valid this cycle; writes leave dout untouched.
          if (!r_we) begin
            if (r_owner[0]) r_dout1 <= ram_rdata;
            if (r_owner[1]) r_dout2 <= ram_rdata;
          end
          if (w_own_valid) begin
            r_ack1 <= r_owner[0];
            r_ack2 <= r_owner[1];
          end else begin
            // Requester went away: the access is done, just release ownership.
            r_owner <= 2'b00;
          end
        end
        ST_RESP: begin
          if (!w_own_valid) begin
            r_ack1  <= 1'b0;
            r_ack2  <= 1'b0;
            r_owner <= 2'b00;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The strobe is gated by reset so an access coinciding with reset never lands.
  assign ram_en    = (r_state == ST_ACCESS) & rst;
  assign ram_we    = ram_en & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign req1_dout = r_dout1;
  assign req2_dout = r_dout2;
  assign req1_ack  = r_ack1;
  assign req2_ack  = r_ack2;
  assign busy      = (r_state != ST_IDLE);
  assign grant     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses LATENCY=16, instance 1 uses LATENCY=1.
// Each instance has its own RAM model and an ack-driven scoreboard monitor.
// Directed steps run from one initial block; the monitors pop expected results on ack.
module tb_mem_port_arbiter;

  typedef struct {
    int          port;
    logic [127:0] data;
    logic [11:0]  line;
    logic         we;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic         rst [2];
  logic         v1 [2], rw1 [2], v2 [2], rw2 [2];
  logic [13:0]  a1 [2], a2 [2];
  logic [127:0] d1 [2], d2 [2];
  logic [127:0] q1 [2], q2 [2];
  logic         k1 [2], k2 [2];
  logic         ram_en [2], ram_we [2], busy [2];
  logic [11:0]  ram_addr [2];
  logic [127:0] ram_wdata [2];
  logic [1:0]   grant [2];

  exp_t sbq [2][$];

  function automatic logic [127:0] pat(input logic [11:0] line);
    return {4'hA, line, 96'h0123_4567_89AB_CDEF_0F1E_2D3C, 16'hCAFE};
  endfunction

  task automatic check_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 16 : 1;

    logic [127:0] mem [4096];
    logic [127:0] rdata;
    int           g_edge = 0, en_cnt = 0, en_edge = 0, fall_edge = 0, gap = 0;
    logic [11:0]  en_line;
    logic         en_we;
    logic [1:0]   pgnt = 2'b00;
    logic         pk1 = 1'b0, pk2 = 1'b0;
    logic [127:0] mdl [2];

    mem_port_arbiter #(.LATENCY(LAT), .RAM_AW(12)) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .req1_valid (v1[gi]),
      .req1_rd_wr (rw1[gi]),
      .req1_addr  (a1[gi]),
      .req1_din   (d1[gi]),
      .req1_dout  (q1[gi]),
      .req1_ack   (k1[gi]),
      .req2_valid (v2[gi]),
      .req2_rd_wr (rw2[gi]),
      .req2_addr  (a2[gi]),
      .req2_din   (d2[gi]),
      .req2_dout  (q2[gi]),
      .req2_ack   (k2[gi]),
      .ram_en     (ram_en[gi]),
      .ram_we     (ram_we[gi]),
      .ram_addr   (ram_addr[gi]),
      .ram_wdata  (ram_wdata[gi]),
      .ram_rdata  (rdata),
      .busy       (busy[gi]),
      .grant      (grant[gi])
    );

    initial begin
      for (int j = 0; j < 4096; j++) mem[j] <= pat(12'(j));
    end

    always @(posedge clk) begin
      if (ram_en[gi]) begin
        if (ram_we[gi]) mem[ram_addr[gi]] <= ram_wdata[gi];
        rdata <= mem[ram_addr[gi]];
      end
    end

    always @(negedge clk) begin
      exp_t e;
      int   p;
      if (!rst[gi]) begin
        mdl[0] = '0;
        mdl[1] = '0;
      end
      if (grant[gi] != 2'b00 && pgnt == 2'b00) begin
        gap    = cyc - fall_edge;
        g_edge = cyc;
        en_cnt = 0;
      end
      if (ram_en[gi]) begin
        en_cnt++;
        en_edge = cyc;
        en_line = ram_addr[gi];
        en_we   = ram_we[gi];
      end
      if ((k1[gi] && !pk1) || (k2[gi] && !pk2)) begin
        p = k1[gi] ? 1 : 2;
        check_i("sb_has_entry", int'(sbq[gi].size() != 0), 1);
        if (sbq[gi].size() != 0) begin
          e = sbq[gi].pop_front();
          check_i("ack_port", p, e.port);
          check_i("ack_latency", cyc - g_edge, LAT + 2);
          check_i("ram_en_once", en_cnt, 1);
          check_i("ram_en_offset", en_edge - g_edge, LAT);
          check_i("ram_addr", int'(en_line), int'(e.line));
          check_i("ram_we", int'(en_we), int'(e.we));
          check_i("grant_owner", int'(grant[gi]), p);
          if (!e.we) mdl[p-1] = e.data;
          check_d("dout_owner", (p == 1) ? q1[gi] : q2[gi], mdl[p-1]);
          check_d("dout_other", (p == 1) ? q2[gi] : q1[gi], mdl[2-p]);
        end
      end
      if ((pk1 && !k1[gi]) || (pk2 && !k2[gi])) fall_edge = cyc;
      pgnt = grant[gi];
      pk1  = k1[gi];
      pk2  = k2[gi];
    end
  end

  task automatic raise(input int i, input int p, input logic wr, input logic [13:0] a,
                       input logic [127:0] d);
    if (p == 1) begin
      v1[i] = 1'b1; rw1[i] = wr; a1[i] = a; d1[i] = d;
    end else begin
      v2[i] = 1'b1; rw2[i] = wr; a2[i] = a; d2[i] = d;
    end
  endtask

  task automatic expect_txn(input int i, input int p, input logic [127:0] data,
                            input logic [11:0] line, input logic we);
    exp_t e;
    e.port = p; e.data = data; e.line = line; e.we = we;
    sbq[i].push_back(e);
  endtask

  task automatic drain(input int i, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (k1[i]) v1[i] = 1'b0;
      if (k2[i]) v2[i] = 1'b0;
      done = !busy[i] && !v1[i] && !v2[i] && !k1[i] && !k2[i];
    end
    check_i("drain_in_budget", int'(done), 1);
  endtask

  task automatic wait_grant(input int i, input int budget, output int g);
    bit seen = 1'b0;
    g = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (grant[i] != 2'b00) begin
        seen = 1'b1;
        g    = cyc;
      end
    end
    check_i("grant_in_budget", int'(seen), 1);
  endtask

  task automatic check_reset(input int i);
    check_i("rst_ack1", int'(k1[i]), 0);
    check_i("rst_ack2", int'(k2[i]), 0);
    check_d("rst_dout1", q1[i], '0);
    check_d("rst_dout2", q2[i], '0);
    check_i("rst_ram_en", int'(ram_en[i]), 0);
    check_i("rst_ram_we", int'(ram_we[i]), 0);
    check_i("rst_ram_addr", int'(ram_addr[i]), 0);
    check_d("rst_ram_wdata", ram_wdata[i], '0);
    check_i("rst_grant", int'(grant[i]), 0);
    check_i("rst_busy", int'(busy[i]), 0);
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] wdat;
    logic [11:0]  ln;
    int           g;
    int           idle_at;
    bit           seen_ack;
    int           s1, s2;
    bit           done;

    ones = {16{8'h11}};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      v1[i] = 1'b0; rw1[i] = 1'b0; a1[i] = '0; d1[i] = '0;
      v2[i] = 1'b0; rw2[i] = 1'b0; a2[i] = '0; d2[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);

    // Tie straight after reset: port 1 first, port 2 one cycle after ack falls.
    expect_txn(0, 1, pat(12'h010), 12'h010, 1'b0);
    expect_txn(0, 2, pat(12'h020), 12'h020, 1'b0);
    raise(0, 1, 1'b0, 14'h0043, '0);
    raise(0, 2, 1'b0, 14'h0081, '0);
    drain(0, 200);
    check_i("tie_gap", g_inst[0].gap, 1);

    // Single read of line 0x005 through port 1.
    expect_txn(0, 1, pat(12'h005), 12'h005, 1'b0);
    raise(0, 1, 1'b0, 14'h0014, '0);
    drain(0, 100);
    check_d("read_cafe", q1[0], pat(12'h005));

    // Port 2 write to 0x3FFC, then port 1 reads 0x3FFF (same line).
    expect_txn(0, 2, '0, 12'hFFF, 1'b1);
    raise(0, 2, 1'b1, 14'h3FFC, ones);
    drain(0, 100);
    check_d("mem_written", g_inst[0].mem[12'hFFF], ones);
    expect_txn(0, 1, ones, 12'hFFF, 1'b0);
    raise(0, 1, 1'b0, 14'h3FFF, '0);
    drain(0, 100);
    check_d("readback", q1[0], ones);

    // Abort: port 1 drops valid during WAIT of a write.
    wdat = 128'hABCD_EF01_2345_6789_9876_5432_10FE_DCBA;
    raise(0, 1, 1'b1, 14'h0040, wdat);
    wait_grant(0, 10, g);
    repeat (3) @(negedge clk);
    v1[0] = 1'b0;
    seen_ack = 1'b0;
    idle_at  = -1;
    for (int n = 0; n < 40 && idle_at < 0; n++) begin
      @(negedge clk);
      if (k1[0]) seen_ack = 1'b1;
      if (!busy[0]) idle_at = cyc;
    end
    check_i("abort_idle_edge", idle_at - g, 18);
    check_i("abort_no_ack", int'(seen_ack), 0);
    check_d("abort_committed", g_inst[0].mem[12'h010], wdat);
    check_d("abort_dout_hold", q1[0], ones);

    // Reset asserted while the FSM sits in ACCESS of a port 2 write.
    raise(0, 2, 1'b1, 14'h00C0, ~wdat);
    wait_grant(0, 10, g);
    repeat (16) @(negedge clk);
    check_i("access_reached", int'(ram_en[0]), 1);
    rst[0] = 1'b0;
    #1;
    check_i("rst_gates_en", int'(ram_en[0]), 0);
    check_i("rst_gates_we", int'(ram_we[0]), 0);
    @(negedge clk);
    v2[0] = 1'b0;
    check_reset(0);
    check_d("rst_no_write", g_inst[0].mem[12'h030], pat(12'h030));
    @(negedge clk);
    rst[0] = 1'b1;

    // LATENCY=1 instance: both ports re-request back to back, served alternately.
    for (int k = 0; k < 4; k++) begin
      expect_txn(1, 1, pat(12'h100 + 12'(k)), 12'h100 + 12'(k), 1'b0);
      expect_txn(1, 2, pat(12'h200 + 12'(k)), 12'h200 + 12'(k), 1'b0);
    end
    raise(1, 1, 1'b0, {12'h100, 2'($urandom)}, '0);
    raise(1, 2, 1'b0, {12'h200, 2'($urandom)}, '0);
    s1 = 1;
    s2 = 1;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (k1[1]) v1[1] = 1'b0;
      else if (!v1[1] && s1 < 4) begin
        ln = 12'h100 + 12'(s1);
        raise(1, 1, 1'b0, {ln, 2'($urandom)}, '0);
        s1++;
      end
      if (k2[1]) v2[1] = 1'b0;
      else if (!v2[1] && s2 < 4) begin
        ln = 12'h200 + 12'(s2);
        raise(1, 2, 1'b0, {ln, 2'($urandom)}, '0);
        s2++;
      end
      done = (s1 == 4) && (s2 == 4) && !busy[1] && !v1[1] && !v2[1] && !k1[1] && !k2[1];
    end
    check_i("alt_done", int'(done), 1);
    check_i("alt_all_served", sbq[1].size(), 0);
    check_i("a_all_served", sbq[0].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL provide these parameters:
- LATENCY, default 16, idle cycles between grant and RAM access; legal range 1..255.
- RAM_AW, default 12, RAM word-address width; 128-bit lines.

REQ-002 The block SHALL provide these ports. There is one clock; reset is synchronous and active-low.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req1_valid  in  1  port-1 request; held high until ack is seen.
- req1_rd_wr  in  1  port-1 direction: 1 = write, 0 = read.
- req1_addr  in  14  port-1 address; bits [13:2] select the line.
- req1_din  in  128  port-1 write line.
- req1_dout  out  128  port-1 read line.
- req1_ack  out  1  port-1 completion.
- req2_valid / req2_rd_wr / req2_addr / req2_din / req2_dout / req2_ack  same widths and meanings as port 1, for port 2.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM line address.
- ram_wdata  out  128  RAM write data.
- ram_rdata  in  128  RAM read data, valid one cycle after ram_en.
- busy  out  1  high whenever the state is not IDLE.
- grant  out  2  one-hot owner; 2'b00 when idle.

Function
REQ-003 The FSM SHALL have five states: IDLE, WAIT, ACCESS, CAPTURE, RESP.
REQ-004 IDLE: if any reqN_valid is sampled high, the FSM SHALL grant one port, latch its rd_wr, addr[13:2] and din, load the counter with LATENCY-1, and go to WAIT.
REQ-005 Arbitration SHALL be round-robin. When both ports are valid, the port not granted last wins. After reset, port 1 wins the first tie.
REQ-006 WAIT: the counter SHALL decrement once per cycle. At count 0 the FSM SHALL go to ACCESS, so WAIT lasts exactly LATENCY cycles.
REQ-007 ACCESS: ram_en=1 for exactly one cycle, with ram_we=latched rd_wr, ram_addr=latched line and ram_wdata=latched din. At all other times ram_en=0 and ram_we=0.
REQ-008 CAPTURE: for a read, the granted reqN_dout SHALL load ram_rdata. For a write, reqN_dout SHALL hold its value. The granted reqN_ack SHALL rise at the CAPTURE exit edge, i.e. LATENCY+2 cycles after the grant edge.
REQ-009 RESP: ack SHALL stay high while the granted valid stays high. On the first edge sampling that valid low, ack SHALL fall and the FSM SHALL return to IDLE. The next grant happens no earlier than the following edge.
REQ-010 Abort: if the granted valid is low when sampled in CAPTURE, the access SHALL still complete (a write is committed) but no ack SHALL be raised, and the FSM SHALL go directly to IDLE.
REQ-011 A non-granted port's valid SHALL be held pending, never dropped. Its ack and dout SHALL stay unchanged until that port is served.
REQ-012 reqN_addr[1:0] SHALL be ignored. Request inputs SHALL be sampled only in IDLE, so changes after the grant have no effect.
REQ-013 A port that holds valid high across RESP→IDLE without first dropping it SHALL be treated as a new request.

Reset
REQ-014 While rst=0 at an edge, the block SHALL set: state=IDLE, counter=0, req1_ack=req2_ack=0, req1_dout=req2_dout=0, ram_en=ram_we=0, ram_addr=0, ram_wdata=0, grant=0, busy=0, last-grant=port 2.
REQ-015 A reset mid-transaction SHALL abandon the transaction with no RAM write. This holds even if the reset coincides with ACCESS, because ram_en is gated by rst.

Structure
REQ-016 The following SHALL live in the shared define.v header: state encodings, LINE_W=128, MEM_AW=14, default LATENCY.
REQ-017 The round-robin decision SHALL be one sub-module, rr_arb2: two requests in, one-hot grant out, last-grant register inside, update on an accept strobe. Everything else stays flat.

Verification
REQ-018 Single read, LATENCY=16, RAM line 0x005 preloaded with 0x...CAFE: port 1 read at addr 0x0014 → ram_en exactly once at grant+16 with ram_addr=0x005; req1_ack rises at grant+18; req1_dout=0x...CAFE.
REQ-019 Simultaneous request after reset, both ports valid in the same cycle → port 1 served first. Port 2 is granted one cycle after port 1 ack falls, and its ack arrives 18 cycles after that grant.
REQ-020 Write then read-back: port 2 writes 0x1111...1111 to addr 0x3FFC, then port 1 reads addr 0x3FFF → ram_addr=0xFFF both times; port 1 reads 0x1111...1111.
REQ-021 Abort: port 1 drops valid during WAIT of a write → RAM write still occurs; req1_ack stays 0; FSM returns to IDLE at CAPTURE exit.
REQ-022 Reset in ACCESS: rst=0 coincident with ACCESS → ram_en=0 that cycle; RAM contents unchanged; all outputs at reset values on the next cycle.
REQ-023 LATENCY=1 corner: ack at grant+3. Back-to-back alternating requests from both ports → strict alternation (1, 2, 1, 2…) and no lost request.
